fir_addr_gen: RTL and testbench

- Parametrised address generator for the FIR sample delay line.
- Holds the circular write pointer, which can be loaded directly or advanced with modulo wrap.
- On start, walks the delay line backward from the newest sample, one tap address per cycle, for a runtime-selectable tap count.
- Sits between the FIR controller and the sample memory read port. Replaces the plain load-only address register.

---
 rtl/fir_addr_gen.sv | 145 ++++++++++++++
 tb/tb_fir_addr_gen.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/fir_addr_gen.sv
// Address generator for the FIR sample delay line: circular write pointer
// plus a backward tap-address sweep starting at the newest sample.
module fir_addr_gen #(
    parameter int unsigned ADDR_W = 13,
    parameter int unsigned DEPTH  = 8192,
    parameter int unsigned TAP_W  = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic              wr_adv,
    input  logic              start,
    input  logic [TAP_W-1:0]  taps,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_valid,
    output logic              rd_last,
    output logic [TAP_W-1:0]  tap_idx,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [31:0]       DEPTH_V   = 32'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [TAP_W-1:0]  tap_idx_q, tap_idx_d;
    logic [TAP_W-1:0]  ntaps_q, ntaps_d;
    logic              rd_valid_q, rd_valid_d;
    logic              rd_last_q, rd_last_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              ld_ok;
    logic              taps_ok;
    logic [ADDR_W-1:0] wr_inc;
    logic [ADDR_W-1:0] rd_dec;

    assign ld_ok   = 32'(ld_addr) < DEPTH_V;
    assign taps_ok = (taps != '0) && (32'(taps) <= DEPTH_V);
    assign wr_inc  = (wr_addr_q == LAST_ADDR) ? '0 : wr_addr_q + 1'b1;
    assign rd_dec  = (rd_addr_q == '0) ? LAST_ADDR : rd_addr_q - 1'b1;

    always_comb begin
        state_d   = state_q;
        wr_addr_d = wr_addr_q;
        rd_addr_d = rd_addr_q;
        tap_idx_d = tap_idx_q;
        ntaps_d   = ntaps_q;
        rd_last_d = 1'b0;
        done_d    = 1'b0;
        err_d     = 1'b0;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (ld) begin
                    if (ld_ok) wr_addr_d = ld_addr;
                    else       err_d     = 1'b1;
                end else if (wr_adv) begin
                    wr_addr_d = wr_inc;
                end

                if (state_q == S_DONE) begin
                    state_d = S_IDLE;
                end else if (start) begin
                    if (taps_ok) begin
                        // base is the pointer after this cycle's ld/wr_adv
                        state_d   = S_RUN;
                        rd_addr_d = wr_addr_d;
                        tap_idx_d = '0;
                        ntaps_d   = taps;
                        rd_last_d = (taps == TAP_W'(1));
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            S_RUN: begin
                if (ld || wr_adv) err_d = 1'b1;

                if (tap_idx_q == ntaps_q - TAP_W'(1)) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    rd_addr_d = rd_dec;
                    tap_idx_d = tap_idx_q + 1'b1;
                    rd_last_d = (tap_idx_q + TAP_W'(2) == ntaps_q);
                end
            end

            default: state_d = S_IDLE;
        endcase

        busy_d     = (state_d == S_RUN);
        rd_valid_d = (state_d == S_RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            wr_addr_q  <= '0;
            rd_addr_q  <= '0;
            tap_idx_q  <= '0;
            ntaps_q    <= '0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_addr_q  <= wr_addr_d;
            rd_addr_q  <= rd_addr_d;
            tap_idx_q  <= tap_idx_d;
            ntaps_q    <= ntaps_d;
            rd_valid_q <= rd_valid_d;
            rd_last_q  <= rd_last_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign wr_addr  = wr_addr_q;
    assign rd_addr  = rd_addr_q;
    assign rd_valid = rd_valid_q;
    assign rd_last  = rd_last_q;
    assign tap_idx  = tap_idx_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_fir_addr_gen.sv
// Scoreboard bench for fir_addr_gen: expected tap beats are queued when a
// sweep is accepted and popped by an independent output monitor.
module tb_fir_addr_gen;

    localparam int AW    = 4;
    localparam int DEPTH = 12;
    localparam int TW    = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          ld = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic          wr_adv = 1'b0;
    logic          start = 1'b0;
    logic [TW-1:0] taps = '0;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;
    logic          rd_valid;
    logic          rd_last;
    logic [TW-1:0] tap_idx;
    logic          busy;
    logic          done;
    logic          err;

    fir_addr_gen #(
        .ADDR_W(AW),
        .DEPTH (DEPTH),
        .TAP_W (TW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .ld      (ld),
        .ld_addr (ld_addr),
        .wr_adv  (wr_adv),
        .start   (start),
        .taps    (taps),
        .wr_addr (wr_addr),
        .rd_addr (rd_addr),
        .rd_valid(rd_valid),
        .rd_last (rd_last),
        .tap_idx (tap_idx),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int addr;
        int idx;
        bit last;
    } beat_t;

    beat_t exp_q[$];
    int    checks   = 0;
    int    failures = 0;

    // Reference model: pointer value plus the edge window of the current sweep
    int m_wr   = 0;
    int edge_n = 0;
    int e0     = -100;
    int n_sw   = 0;

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Monitor: pops one expected beat for every cycle the DUT presents rd_valid
    initial begin
        beat_t b;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (rd_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("rd_unexpected", 1, 0);
                    end else begin
                        b = exp_q.pop_front();
                        chk("rd_addr", int'(rd_addr), b.addr);
                        chk("tap_idx", int'(tap_idx), b.idx);
                        chk("rd_last", int'(rd_last), int'(b.last));
                    end
                end else begin
                    chk("rd_last_idle", int'(rd_last), 0);
                end
                chk("rd_valid_vs_busy", int'(rd_valid), int'(busy));
            end
        end
    end

    // One clock of stimulus; called and returning at a falling edge
    task automatic cycle(input bit ld_i, input int ld_a, input bit adv_i,
                         input bit st_i, input int tp);
        int e;
        bit in_run;
        bit in_done;
        bit err_exp;
        beat_t b;
        e       = edge_n + 1;
        in_run  = (e >= e0 + 1) && (e <= e0 + n_sw);
        in_done = (e == e0 + n_sw + 1);
        err_exp = 1'b0;
        if (in_run) begin
            if (ld_i || adv_i) err_exp = 1'b1;
        end else begin
            if (ld_i) begin
                if (ld_a < DEPTH) m_wr = ld_a;
                else              err_exp = 1'b1;
            end else if (adv_i) begin
                m_wr = (m_wr + 1) % DEPTH;
            end
            if (st_i && !in_done) begin
                if (tp == 0 || tp > DEPTH) begin
                    err_exp = 1'b1;
                end else begin
                    e0   = e;
                    n_sw = tp;
                    for (int k = 0; k < tp; k++) begin
                        b.addr = ((m_wr - k) % DEPTH + DEPTH) % DEPTH;
                        b.idx  = k;
                        b.last = (k == tp - 1);
                        exp_q.push_back(b);
                    end
                end
            end
        end
        ld      = ld_i;
        ld_addr = AW'(ld_a);
        wr_adv  = adv_i;
        start   = st_i;
        taps    = TW'(tp);
        @(posedge clk);
        edge_n = e;
        @(negedge clk);
        chk("wr_addr", int'(wr_addr), m_wr);
        chk("err", int'(err), int'(err_exp));
        chk("busy", int'(busy), int'((e >= e0) && (e <= e0 + n_sw - 1)));
        chk("done", int'(done), int'(e == e0 + n_sw));
    endtask

    task automatic idle(input int cnt);
        for (int i = 0; i < cnt; i++) cycle(0, 0, 0, 0, 0);
    endtask

    initial begin
        #1 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("reset_outputs", int'({wr_addr, rd_addr, rd_valid, rd_last, tap_idx, busy, done, err}), 0);
        rst = 1'b0;

        // basic sweep
        cycle(1, 5, 0, 0, 0);
        cycle(0, 0, 0, 1, 3);
        idle(5);
        // read wrap and pointer wrap
        cycle(1, 1, 0, 0, 0);
        cycle(0, 0, 0, 1, 4);
        idle(6);
        cycle(1, 11, 0, 0, 0);
        cycle(0, 0, 1, 0, 0);
        // ld beats wr_adv; start snapshots the advanced pointer
        cycle(1, 4, 0, 0, 0);
        cycle(1, 9, 1, 0, 0);
        cycle(1, 7, 0, 0, 0);
        cycle(0, 0, 1, 1, 2);
        idle(4);
        // rejected requests
        cycle(1, 12, 0, 0, 0);
        idle(1);
        cycle(0, 0, 0, 1, 0);
        idle(1);
        cycle(0, 0, 0, 1, 13);
        idle(1);
        // wr_adv and start inside RUN, start inside DONE
        cycle(1, 3, 0, 0, 0);
        cycle(0, 0, 0, 1, 3);
        cycle(0, 0, 1, 0, 0);
        cycle(0, 0, 0, 1, 5);
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 4);
        idle(3);

        // asynchronous reset in the middle of a sweep
        cycle(1, 6, 0, 0, 0);
        cycle(0, 0, 0, 1, 8);
        idle(2);
        #2 rst = 1'b1;
        #1 chk("async_reset_outputs", int'({wr_addr, rd_addr, rd_valid, rd_last, tap_idx, busy, done, err}), 0);
        exp_q.delete();
        m_wr = 0;
        e0   = -100;
        n_sw = 0;
        @(negedge clk);
        rst = 1'b0;
        cycle(0, 0, 0, 1, 2);
        idle(4);

        for (int i = 0; i < 300; i++) begin
            cycle($urandom_range(7) == 0, int'($urandom_range(15)), $urandom_range(3) == 0,
                  $urandom_range(5) == 0, int'($urandom_range(15)));
        end
        idle(16);
        chk("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
